nlp_frame_sequencer: RTL and testbench



---
 rtl/nlp_frame_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_nlp_frame_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nlp_frame_sequencer.sv
// Per-frame controller for the NLP pitch back-end: sequences fill, peak search and
// post-processing, owns the Fw RAM and its port mux, and guards each stage with a watchdog.
module nlp_frame_sequencer #(
   parameter int            N       = 32,
   parameter int            N1      = 80,
   parameter int            TIMEOUT = 4095,
   parameter logic [N-1:0]  F0_INIT = {16'd50, 16'd0}
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_nlp,
   output logic          done_nlp,
   output logic          err_nlp,
   output logic [N-1:0]  best_f0,
   output logic          startfw,
   input  logic          donefw,
   input  logic [9:0]    fw_addr,
   input  logic [N1-1:0] fw_wdata,
   input  logic          fw_we,
   output logic          startgm,
   input  logic          donegm,
   input  logic [9:0]    gm_addr,
   input  logic [N1-1:0] gmax,
   input  logic [9:0]    gmax_bin,
   output logic          startpp,
   input  logic          donepp,
   input  logic [9:0]    pp_addr,
   input  logic [N-1:0]  pp_best_f0,
   output logic [N1-1:0] pp_gmax,
   output logic [9:0]    pp_gmax_bin,
   output logic [N-1:0]  pp_prev_f0,
   output logic [9:0]    ram_addr,
   output logic [N1-1:0] ram_wdata,
   output logic          ram_we,
   output logic [N1-1:0] ram_q_pp
);

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_START_FW,
      S_WAIT_FW,
      S_START_GM,
      S_WAIT_GM,
      S_START_PP,
      S_WAIT_PP,
      S_COMMIT,
      S_FINISH,
      S_ABORT
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wd_q, wd_d;
   logic          err_q, err_d;
   logic [N-1:0]  best_q, best_d;
   logic [N1-1:0] ppg_q, ppg_d;
   logic [9:0]    ppb_q, ppb_d;
   logic [N-1:0]  prev_q, prev_d;

   logic [N1-1:0] fw_mem [0:1023];
   logic [N1-1:0] rd_q, rd_d;
   logic [N1-1:0] rq_q, rq_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         wd_q    <= '0;
         err_q   <= 1'b0;
         best_q  <= '0;
         ppg_q   <= '0;
         ppb_q   <= '0;
         prev_q  <= F0_INIT;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
         best_q  <= best_d;
         ppg_q   <= ppg_d;
         ppb_q   <= ppb_d;
         prev_q  <= prev_d;
      end
   end

   // A done arriving on the last allowed wait cycle wins over the abort.
   always_comb begin
      state_d = state_q;
      wd_d    = wd_q;
      err_d   = err_q;
      best_d  = best_q;
      ppg_d   = ppg_q;
      ppb_d   = ppb_q;
      prev_d  = prev_q;
      case (state_q)
         S_IDLE: begin
            if (start_nlp) begin
               state_d = S_START_FW;
               err_d   = 1'b0;
            end
         end
         S_START_FW: begin
            wd_d    = '0;
            state_d = S_WAIT_FW;
         end
         S_WAIT_FW: begin
            if (donefw) begin
               state_d = S_START_GM;
            end else if (wd_q == WD_LAST) begin
               state_d = S_ABORT;
            end else begin
               wd_d = wd_q + CW'(1);
            end
         end
         S_START_GM: begin
            wd_d    = '0;
            state_d = S_WAIT_GM;
         end
         S_WAIT_GM: begin
            if (donegm) begin
               ppg_d   = gmax;
               ppb_d   = gmax_bin;
               state_d = S_START_PP;
            end else if (wd_q == WD_LAST) begin
               state_d = S_ABORT;
            end else begin
               wd_d = wd_q + CW'(1);
            end
         end
         S_START_PP: begin
            wd_d    = '0;
            state_d = S_WAIT_PP;
         end
         S_WAIT_PP: begin
            if (donepp) begin
               best_d  = pp_best_f0;
               state_d = S_COMMIT;
            end else if (wd_q == WD_LAST) begin
               state_d = S_ABORT;
            end else begin
               wd_d = wd_q + CW'(1);
            end
         end
         S_COMMIT: begin
            prev_d  = best_q;
            state_d = S_FINISH;
         end
         S_ABORT: begin
            // Repeat the last good pitch so the encoder still gets a usable value.
            err_d   = 1'b1;
            best_d  = prev_q;
            state_d = S_FINISH;
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      startfw   = (state_q == S_START_FW);
      startgm   = (state_q == S_START_GM);
      startpp   = (state_q == S_START_PP);
      done_nlp  = (state_q == S_FINISH);
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      case (state_q)
         S_START_FW, S_WAIT_FW: begin
            ram_addr  = fw_addr;
            ram_wdata = fw_wdata;
            ram_we    = fw_we;
         end
         S_START_GM, S_WAIT_GM: begin
            ram_addr = gm_addr;
         end
         S_START_PP, S_WAIT_PP: begin
            ram_addr = pp_addr;
         end
         default: begin
            ram_addr = '0;
         end
      endcase
   end

   assign err_nlp     = err_q;
   assign best_f0     = best_q;
   assign pp_gmax     = ppg_q;
   assign pp_gmax_bin = ppb_q;
   assign pp_prev_f0  = prev_q;

   // Block RAM with registered read plus output register: two cycles address to data.
   always_comb begin
      rd_d = fw_mem[ram_addr];
      rq_d = rd_q;
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         fw_mem[ram_addr] <= ram_wdata;
      end
      rd_q <= rd_d;
      rq_q <= rq_d;
   end

   assign ram_q_pp = rq_q;

endmodule

// File: tb/tb_nlp_frame_sequencer.sv
// Randomized bench for nlp_frame_sequencer: a timeline-based frame model sets per-cycle
// expectations and one negedge process compares every output against them.
module tb_nlp_frame_sequencer;
   localparam int          N   = 32;
   localparam int          N1  = 80;
   localparam int          TO  = 4095;
   localparam logic [31:0] F0I = 32'h0032_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start_nlp = 1'b0;
   logic          done_nlp, err_nlp;
   logic [N-1:0]  best_f0;
   logic          startfw, startgm, startpp;
   logic          donefw = 1'b0, donegm = 1'b0, donepp = 1'b0;
   logic [9:0]    fw_addr = '0, gm_addr = '0, pp_addr = '0;
   logic [N1-1:0] fw_wdata = '0;
   logic          fw_we = 1'b0;
   logic [N1-1:0] gmax = '0;
   logic [9:0]    gmax_bin = '0;
   logic [N-1:0]  pp_best_f0 = '0;
   logic [N1-1:0] pp_gmax;
   logic [9:0]    pp_gmax_bin;
   logic [N-1:0]  pp_prev_f0;
   logic [9:0]    ram_addr;
   logic [N1-1:0] ram_wdata;
   logic          ram_we;
   logic [N1-1:0] ram_q_pp;

   nlp_frame_sequencer dut (
      .clk(clk), .rst(rst), .start_nlp(start_nlp), .done_nlp(done_nlp), .err_nlp(err_nlp),
      .best_f0(best_f0), .startfw(startfw), .donefw(donefw), .fw_addr(fw_addr),
      .fw_wdata(fw_wdata), .fw_we(fw_we), .startgm(startgm), .donegm(donegm),
      .gm_addr(gm_addr), .gmax(gmax), .gmax_bin(gmax_bin), .startpp(startpp),
      .donepp(donepp), .pp_addr(pp_addr), .pp_best_f0(pp_best_f0), .pp_gmax(pp_gmax),
      .pp_gmax_bin(pp_gmax_bin), .pp_prev_f0(pp_prev_f0), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q_pp(ram_q_pp)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Expected outputs for the current cycle; owner: 0 none, 1 fill, 2 peak, 3 post.
   logic          e_sfw = 0, e_sgm = 0, e_spp = 0, e_done = 0, e_err = 0;
   logic [31:0]   e_best = '0, e_prev = F0I;
   logic [79:0]   e_ppg = '0;
   logic [9:0]    e_ppb = '0;
   int            e_owner = 0;
   logic [79:0]   cur_g;
   logic [9:0]    cur_b;
   logic [31:0]   cur_bf;

   logic [79:0]   mem_m [int];
   logic          m_rd_v = 0, m_q_v = 0;
   logic [79:0]   m_rd = '0, m_q = '0;
   logic [9:0]    xa;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [9:0] f_addr();
      case (e_owner)
         1: return fw_addr;
         2: return gm_addr;
         3: return pp_addr;
         default: return 10'd0;
      endcase
   endfunction

   function automatic logic f_we();
      return (e_owner == 1) ? fw_we : 1'b0;
   endfunction

   function automatic logic [79:0] f_wdata();
      return (e_owner == 1) ? fw_wdata : 80'd0;
   endfunction

   // RAM model: write when the fill stage owns the port, data two edges after the address.
   always @(posedge clk) begin
      m_q_v = m_rd_v;
      m_q   = m_rd;
      xa    = f_addr();
      m_rd_v = mem_m.exists(int'(xa));
      if (m_rd_v) m_rd = mem_m[int'(xa)];
      if (f_we()) mem_m[int'(xa)] = f_wdata();
   end

   always @(negedge clk) begin
      chk("startfw", 80'(startfw), 80'(e_sfw));
      chk("startgm", 80'(startgm), 80'(e_sgm));
      chk("startpp", 80'(startpp), 80'(e_spp));
      chk("done_nlp", 80'(done_nlp), 80'(e_done));
      chk("err_nlp", 80'(err_nlp), 80'(e_err));
      chk("best_f0", 80'(best_f0), 80'(e_best));
      chk("pp_prev_f0", 80'(pp_prev_f0), 80'(e_prev));
      chk("pp_gmax", pp_gmax, e_ppg);
      chk("pp_gmax_bin", 80'(pp_gmax_bin), 80'(e_ppb));
      chk("ram_addr", 80'(ram_addr), 80'(f_addr()));
      chk("ram_wdata", ram_wdata, f_wdata());
      chk("ram_we", 80'(ram_we), 80'(f_we()));
      if (m_q_v) chk("ram_q_pp", ram_q_pp, m_q);
   end

   function automatic logic [9:0] pick_addr();
      if ($urandom_range(0, 9) == 0) return 10'h3FF;
      return 10'($urandom_range(0, 15));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      fw_addr    = pick_addr();
      gm_addr    = pick_addr();
      pp_addr    = pick_addr();
      fw_we      = 1'($urandom_range(0, 1));
      fw_wdata   = {16'($urandom), $urandom, $urandom};
      gmax       = {16'($urandom), $urandom, $urandom};
      gmax_bin   = 10'($urandom);
      pp_best_f0 = $urandom;
   endtask

   task automatic set_done(input int s, input logic v);
      case (s)
         0: donefw = v;
         1: donegm = v;
         default: donepp = v;
      endcase
   endtask

   task automatic set_reset_exp();
      e_sfw = 0; e_sgm = 0; e_spp = 0; e_done = 0; e_err = 0;
      e_best = '0; e_prev = F0I; e_ppg = '0; e_ppb = '0; e_owner = 0;
   endtask

   // Called on the first cycle of a wait; done on wait cycle d (1..TO) succeeds, d=0 never.
   // res: 1 done, 0 watchdog, 2 reset applied on wait cycle rk.
   task automatic run_wait(input int s, input int d, input int rk, output int res);
      res = 0;
      for (int k = 1; k <= TO; k++) begin
         if (k == rk) begin
            rst = 1'b0;
            set_reset_exp();
            donefw = 0; donegm = 0; donepp = 0; start_nlp = 0;
            tick();
            rst = 1'b1;
            res = 2;
            break;
         end
         set_done(s, (k == d));
         if (k == d) begin
            if (s == 1) begin gmax = cur_g; gmax_bin = cur_b; end
            if (s == 2) pp_best_f0 = cur_bf;
         end
         tick();
         if (k == d) begin res = 1; break; end
         if (k == TO) begin res = 0; break; end
      end
   endtask

   task automatic frame(input int dfw, input int dgm, input int dpp, input logic [79:0] g,
                        input logic [9:0] b, input logic [31:0] bf, input bit hold,
                        input int rst_pp);
      int res;
      cur_g = g; cur_b = b; cur_bf = bf;
      start_nlp = 1;
      tick();
      if (!hold) start_nlp = 0;
      e_sfw = 1; e_owner = 1; e_err = 0;
      tick();
      e_sfw = 0;
      run_wait(0, dfw, 0, res);
      if (res == 1) begin
         e_sgm = 1; e_owner = 2;
         tick();
         donefw = 0; e_sgm = 0;
         run_wait(1, dgm, 0, res);
         if (res == 1) begin
            e_ppg = g; e_ppb = b; e_spp = 1; e_owner = 3;
            tick();
            donegm = 0; e_spp = 0;
            run_wait(2, dpp, rst_pp, res);
            if (res == 1) begin
               e_best = bf; e_owner = 0;
               tick();
               donepp = 0; e_prev = e_best; e_done = 1;
               tick();
               e_done = 0;
            end
         end
      end
      if (res == 0) begin
         e_owner = 0; e_sfw = 0; e_sgm = 0; e_spp = 0;
         tick();
         donefw = 0; donegm = 0; donepp = 0;
         e_err = 1; e_best = e_prev; e_done = 1;
         tick();
         e_done = 0;
      end
   endtask

   initial begin
      set_reset_exp();
      repeat (3) tick();
      chk("reset_best", 80'(best_f0), 80'd0);
      chk("reset_prev", 80'(pp_prev_f0), 80'(32'h0032_0000));
      rst = 1'b1;
      repeat (2) tick();

      // Watchdog: peak search never answers.
      frame(4, 0, 3, 80'd1, 10'd1, 32'd1, 0, 0);
      chk("wd_err", 80'(err_nlp), 80'd1);
      chk("wd_best", 80'(best_f0), 80'(32'h0032_0000));
      chk("wd_prev", 80'(pp_prev_f0), 80'(32'h0032_0000));
      repeat (3) tick();

      // Normal frame with the documented operands.
      frame(20, 10, 6, 80'h2DED36, 10'd40, {16'd125, 16'd0}, 0, 0);
      chk("nf_gmax", pp_gmax, 80'h2DED36);
      chk("nf_bin", 80'(pp_gmax_bin), 80'd40);
      chk("nf_best", 80'(best_f0), 80'(32'h007D_0000));
      chk("nf_prev", 80'(pp_prev_f0), 80'(32'h007D_0000));
      chk("nf_err", 80'(err_nlp), 80'd0);
      chk("model_prev", 80'(e_prev), 80'(32'h007D_0000));
      repeat (2) tick();

      // Fill done exactly on the last allowed cycle still succeeds.
      frame(TO, 5, 5, 80'h1234, 10'd7, 32'h00AA_8000, 0, 0);
      chk("tb_err", 80'(err_nlp), 80'd0);
      chk("tb_best", 80'(best_f0), 80'(32'h00AA_8000));
      repeat (2) tick();

      // Abort, then back-to-back frames with start held high through the first.
      frame(3, 0, 3, 80'd2, 10'd2, 32'd2, 0, 0);
      frame(7, 4, 9, 80'hBEEF, 10'd99, 32'h0064_0000, 1, 0);
      frame(5, 6, 2, 80'hCAFE, 10'd12, 32'h0050_0000, 0, 0);
      chk("b2b_prev", 80'(pp_prev_f0), 80'(32'h0050_0000));
      chk("b2b_err", 80'(err_nlp), 80'd0);
      repeat (2) tick();

      // Reset on the third WAIT_PP cycle.
      frame(3, 3, 10, 80'h77, 10'd3, 32'h0011_0000, 0, 3);
      chk("rst_prev", 80'(pp_prev_f0), 80'(32'h0032_0000));
      chk("rst_best", 80'(best_f0), 80'd0);
      repeat (4) tick();

      for (int f = 0; f < 25; f++) begin
         bit hold;
         hold = ($urandom_range(0, 4) == 0);
         frame($urandom_range(1, 25), $urandom_range(1, 25), $urandom_range(1, 25),
               {16'($urandom), $urandom, $urandom}, 10'($urandom), $urandom, hold, 0);
         if (!hold) repeat ($urandom_range(0, 3)) tick();
      end
      start_nlp = 0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
